// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Segment vectors are ordered {g,f,e,d,c,b,a}; codes below are active-low
// (0 = segment lit). Index the table with a hex nibble.
package seg7_pkg;

  // Bit position of each segment inside a 7-bit segment vector.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // All segments dark, active-low.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low glyphs for 0..9, A, b, C, d, E, F.
  localparam logic [6:0] SEG_CODES [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to active-low seven-segment glyph lookup.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports:
//   nibble    in   4  hex value to display
//   seg_code  out  7  active-low {g,f,e,d,c,b,a}
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_code
);

  assign seg_code = SEG_CODES[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver with frame-aligned shadow register.
// Latency: one cycle from scan state to registered seg/dp/an outputs.
// Backpressure: none; load always accepted, newest pending data wins.
//
// Ports:
//   clk, reset     clock; asynchronous active-high reset
//   enable         0 = all digits dark, scan counters hold
//   load           strobe capturing data/dp_mask into the pending register
//   data           NUM_DIGITS hex nibbles, nibble 0 = rightmost digit
//   dp_mask        per-digit decimal point request
//   seg, dp, an    registered segment, decimal point and digit enables
//   frame_done     one-cycle pulse as the last digit's slot ends
//
// Optional feature: define SEG7_LZB_EN for leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [CW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] disp_data;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [4*NUM_DIGITS-1:0] pend_data;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_flag;

  logic                    tick;
  logic                    wrap;
  logic [3:0]              cur_nibble;
  logic                    cur_dp;
  logic                    blank;
  logic [6:0]              dec_code;
  logic [NUM_DIGITS-1:0]   an_hot;
  logic [6:0]              seg_lo;
  logic                    dp_lit;

  assign tick = enable && (presc == CW'(SCAN_DIV - 1));
  assign wrap = tick && (idx == IW'(NUM_DIGITS - 1));

  // Select the nibble and dp bit of the digit currently being scanned.
  always_comb begin
    cur_nibble = '0;
    cur_dp     = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nibble = disp_data[4*i +: 4];
        cur_dp     = disp_dp[i];
      end
    end
  end

`ifdef SEG7_LZB_EN
  // Walk from the most significant digit down; hi_zero stays set only while
  // every nibble so far is zero and no decimal point has been requested, so
  // a dp on digit j keeps j and everything below it decoded.
  logic hi_zero;
  always_comb begin
    blank   = 1'b0;
    hi_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      hi_zero = hi_zero && (disp_data[4*i +: 4] == 4'h0) && !disp_dp[i];
      if (idx == IW'(i)) begin
        blank = hi_zero;
      end
    end
  end
`else
  assign blank = 1'b0;
`endif

  seg7_hex_decode u_dec (
    .nibble   (cur_nibble),
    .seg_code (dec_code)
  );

  // Next output values in a polarity-neutral form: an one-hot active-high,
  // segments in the package's active-low form, dp active-high.
  assign an_hot = enable ? (NUM_DIGITS'(1) << idx) : '0;
  assign seg_lo = (enable && !blank) ? dec_code : SEG_OFF;
  assign dp_lit = enable && cur_dp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc      <= '0;
      idx        <= '0;
      disp_data  <= '0;
      disp_dp    <= '0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_flag  <= 1'b0;
      frame_done <= 1'b0;
      an         <= ACTIVE_LOW ? '1 : '0;
      seg        <= ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;
      dp         <= ACTIVE_LOW;
    end else begin
      if (enable) begin
        presc <= tick ? '0 : presc + 1'b1;
      end
      if (tick) begin
        idx <= wrap ? '0 : idx + 1'b1;
      end
      frame_done <= wrap;

      // Commit reads the pending value from before this edge, so a load on
      // the wrap tick lands in pending for the following frame.
      if (wrap && pend_flag) begin
        disp_data <= pend_data;
        disp_dp   <= pend_dp;
      end
      if (load) begin
        pend_data <= data;
        pend_dp   <= dp_mask;
        pend_flag <= 1'b1;
      end else if (wrap && pend_flag) begin
        pend_flag <= 1'b0;
      end

      an  <= ACTIVE_LOW ? ~an_hot : an_hot;
      seg <= ACTIVE_LOW ? seg_lo : ~seg_lo;
      dp  <= ACTIVE_LOW ? ~dp_lit : dp_lit;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4 digits, 4-cycle slots, active-low).
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int FR = ND * SD;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp_mask = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .data       (data),
    .dp_mask    (dp_mask),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // pos = number of enabled cycles into the current frame; the lit digit is
  // pos / SD, and the frame ends on the last enabled cycle of the frame.
  logic [6:0] code_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int          pos;
  int          m_d;
  logic        m_wrap;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dpd, m_dpp;
  logic        m_pf;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_fd;

  function automatic logic [6:0] model_seg(input int d);
`ifdef SEG7_LZB_EN
    if (d > 0 && (m_disp >> (4 * d)) == 16'h0 && (m_dpd >> d) == 4'h0) return 7'h7F;
`endif
    return code_tbl[m_disp[4*d +: 4]];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pos    = 0;
      m_disp = '0;
      m_pend = '0;
      m_dpd  = '0;
      m_dpp  = '0;
      m_pf   = 1'b0;
      e_an   = 4'hF;
      e_seg  = 7'h7F;
      e_dp   = 1'b1;
      e_fd   = 1'b0;
    end else begin
      m_d    = pos / SD;
      m_wrap = enable && (pos == FR - 1);
      if (enable) begin
        e_an  = 4'(~(4'b0001 << m_d));
        e_seg = model_seg(m_d);
        e_dp  = ~m_dpd[m_d];
      end else begin
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
      end
      e_fd = m_wrap;
      if (m_wrap && m_pf) begin
        m_disp = m_pend;
        m_dpd  = m_dpp;
        m_pf   = 1'b0;
      end
      if (load) begin
        m_pend = data;
        m_dpp  = dp_mask;
        m_pf   = 1'b1;
      end
      if (enable) pos = (pos + 1) % FR;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("an", 32'(an), 32'(e_an));
      check("seg", 32'(seg), 32'(e_seg));
      check("dp", 32'(dp), 32'(e_dp));
      check("frame_done", 32'(frame_done), 32'(e_fd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

`ifdef SEG7_LZB_EN
  task automatic lzb_frame(input logic [3:0] m, input logic [6:0] e0, input logic [6:0] e1,
                           input logic [6:0] e2, input logic [6:0] e3);
    int n;
    data = 16'h0050; dp_mask = m; load = 1'b1;
    step(1);
    load = 1'b0;
    n = 0;
    do begin
      step(1);
      n++;
    end while (frame_done !== 1'b1 && n < 64);
    check("lzb_wait_frame", 32'(frame_done), 32'd1);
    step(1);  check("lzb_d0", 32'(seg), 32'(e0));
    step(4);  check("lzb_d1", 32'(seg), 32'(e1));
    step(4);  check("lzb_d2", 32'(seg), 32'(e2));
    step(4);  check("lzb_d3", 32'(seg), 32'(e3));
  endtask
`endif

  initial begin
    #1 reset = 1'b1;
    step(1);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_fd", 32'(frame_done), 32'd0);
    reset = 1'b0;                                           // cycle 0

    step(1);  check("first_an", 32'(an), 32'b1110);         // cycle 1
              check("first_seg", 32'(seg), 32'b1000000);
    step(3);  check("slot0_end_an", 32'(an), 32'b1110);     // cycle 4
    step(1);  check("slot1_an", 32'(an), 32'b1101);         // cycle 5
    step(10); check("fd_low", 32'(frame_done), 32'd0);      // cycle 15
    step(1);  check("fd_pulse", 32'(frame_done), 32'd1);    // cycle 16

    step(4);                                                // cycle 20
    data = 16'hBEEF; dp_mask = 4'b0100; load = 1'b1;
    step(1);  load = 1'b0;                                  // cycle 21
    step(4);  check("pre_commit_seg", 32'(seg), 32'b1000000); // cycle 25
              check("pre_commit_dp", 32'(dp), 32'd1);
    step(8);  check("beef_d0_an", 32'(an), 32'b1110);       // cycle 33
              check("beef_d0", 32'(seg), 32'b0001110);
    step(4);  check("beef_d1", 32'(seg), 32'b0000110);      // cycle 37
    step(4);  check("beef_d2", 32'(seg), 32'b0000110);      // cycle 41
              check("beef_d2_dp", 32'(dp), 32'd0);
              check("beef_d2_an", 32'(an), 32'b1011);
    step(4);  check("beef_d3", 32'(seg), 32'b0000011);      // cycle 45

    step(5);  data = 16'h1234; dp_mask = 4'b0000; load = 1'b1; // cycle 50
    step(1);  load = 1'b0;                                  // cycle 51
    step(12); data = 16'h5678; load = 1'b1;                 // cycle 63: wrap tick
    step(1);  load = 1'b0;                                  // cycle 64
    step(1);  check("f1234_d0", 32'(seg), 32'b0011001);     // cycle 65
    step(4);  check("f1234_d1", 32'(seg), 32'b0110000);     // cycle 69
    step(12); check("f5678_d0", 32'(seg), 32'b0000000);     // cycle 81
    step(4);  check("f5678_d1", 32'(seg), 32'b1111000);     // cycle 85

    step(5);  enable = 1'b0;                                // cycle 90
    step(1);  check("dis_an", 32'(an), 32'hF);              // cycle 91
              check("dis_seg", 32'(seg), 32'h7F);
              check("dis_dp", 32'(dp), 32'd1);
    step(9);  enable = 1'b1;                                // cycle 100
    step(1);  check("resume_an", 32'(an), 32'b1011);        // cycle 101
              check("resume_seg", 32'(seg), 32'b0000010);
    step(2);  check("resume_next_an", 32'(an), 32'b0111);   // cycle 103
              check("resume_next_seg", 32'(seg), 32'b0010010);

    // Asynchronous reset while digit 2 is lit.
    for (int i = 0; i < 32 && an !== 4'b1011; i++) step(1);
    check("wait_digit2", 32'(an), 32'b1011);
    #1 reset = 1'b1;
    #1;
    check("async_rst_an", 32'(an), 32'hF);
    check("async_rst_seg", 32'(seg), 32'h7F);
    check("async_rst_dp", 32'(dp), 32'd1);
    check("async_rst_fd", 32'(frame_done), 32'd0);
    step(1);  reset = 1'b0;
    step(1);  check("post_rst_an", 32'(an), 32'b1110);
              check("post_rst_seg", 32'(seg), 32'b1000000);

`ifdef SEG7_LZB_EN
    lzb_frame(4'b0000, 7'b1000000, 7'b0010010, 7'h7F, 7'h7F);
    lzb_frame(4'b1000, 7'b1000000, 7'b0010010, 7'b1000000, 7'b1000000);
`endif

    // Randomized phase, checked every cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      step(1);
      enable  = ($urandom_range(0, 9) != 0);
      load    = ($urandom_range(0, 5) == 0);
      data    = 16'($urandom);
      dp_mask = 4'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #1 reset = 1'b1;
        #2 reset = 1'b0;
      end
    end
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
